// File: rtl/dmem_ctrl.sv
// Load/store sequencer between execute and the data cache: one request in flight,
// range/alignment checking, lane-extracted loads and read-modify-write sub-word stores.

`ifndef _DATA_CACHE_SIZE
`define _DATA_CACHE_SIZE 32'h0000_0FFF
`endif
`ifndef _DATA_CACHE_OFFSET
`define _DATA_CACHE_OFFSET 32'h0000_0000
`endif

module dmem_ctrl #(
  parameter logic [31:0] CACHE_SIZE   = `_DATA_CACHE_SIZE,
  parameter logic [31:0] CACHE_OFFSET = `_DATA_CACHE_OFFSET
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_op,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_aligned_addr;
  logic [32:0] w_rel_top;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic [3:0]  w_lane_hit;

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RSP);
  assign o_mem_op    = (r_state == WR);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  assign w_accept       = i_req_valid && (r_state == IDLE);
  assign w_aligned_addr = {i_req_addr[31:2], 2'b00};

  // 33 bits so the +3 on the last word of the address space cannot wrap.
  assign w_rel_top = {1'b0, w_aligned_addr} - {1'b0, CACHE_OFFSET} + 33'd3;

  assign w_err = (i_req_size == SZ_ILL)
              || ((i_req_size == SZ_HALF) && i_req_addr[0])
              || ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
              || (i_req_addr < CACHE_OFFSET)
              || (w_rel_top > {1'b0, CACHE_SIZE});

  assign w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = i_mem_rdata;
    case (r_size)
      SZ_BYTE: w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = i_mem_rdata;
    endcase
  end

  // Store merge: addressed lanes take store data, the rest keep the cache word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_hit[gi] = (r_size == SZ_BYTE) ? (r_lane == 2'(gi))
                                                  : (r_lane[1] == 1'(gi / 2));
      assign w_merge[8*gi +: 8] = !w_lane_hit[gi]    ? i_mem_rdata[8*gi +: 8] :
                                  (r_size == SZ_HALF) ? r_wdata[8*(gi%2) +: 8] :
                                                        r_wdata[7:0];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_err) begin
            w_state_next = RSP;
          end else if (i_req_we && (i_req_size == SZ_WORD)) begin
            w_state_next = WR;
          end else begin
            w_state_next = RD;
          end
        end
      end
      RD:      w_state_next = r_we ? WR : RSP;
      WR:      w_state_next = RSP;
      RSP:     w_state_next = i_rsp_ready ? IDLE : RSP;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 16'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      if (w_accept) begin
        r_we        <= i_req_we;
        r_size      <= i_req_size;
        r_unsigned  <= i_req_unsigned;
        r_lane      <= i_req_addr[1:0];
        r_wdata     <= i_req_wdata[15:0];
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= w_err;
        if (!w_err) begin
          r_mem_addr <= w_aligned_addr;
          if (i_req_we && (i_req_size == SZ_WORD)) begin
            r_mem_wdata <= i_req_wdata;
          end
        end
      end
      if (r_state == RD) begin
        if (r_we) begin
          r_mem_wdata <= w_merge;
        end else begin
          r_rsp_rdata <= w_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag and latency.

module tb_dmem_ctrl;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_op;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_count = 0;
  int txn_id   = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  bit          seen = 1'b0;
  exp_t        sb[$];

  logic [31:0] mem [0:1023];
  logic [31:0] mem_off;

  dmem_ctrl #(
    .CACHE_SIZE  (32'h0000_0FFF),
    .CACHE_OFFSET(32'h0000_1000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_we      (req_we),
    .i_req_size    (req_size),
    .i_req_unsigned(req_unsigned),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_err     (rsp_err),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_op      (mem_op),
    .i_mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model covering 0x1000..0x1FFF, combinational read, write on the clock.
  assign mem_off   = mem_addr - 32'h1000;
  assign mem_rdata = (mem_addr >= 32'h1000 && mem_addr < 32'h2000) ? mem[mem_off[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_op && mem_addr >= 32'h1000 && mem_addr < 32'h2000) mem[mem_off[11:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (mem_op) begin
        wr_count++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check($sformatf("latency_txn%0d", sb[0].id), 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          end
          if (rsp_ready) begin
            check($sformatf("rdata_txn%0d", sb[0].id), rsp_rdata, sb[0].rdata);
            check($sformatf("err_txn%0d", sb[0].id), {31'h0, rsp_err}, {31'h0, sb[0].err});
            $display("rsp txn%0d rdata=0x%08h err=%0d", sb[0].id, rsp_rdata, rsp_err);
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    int   n;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    txn_id++;
    e.id    = txn_id;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = lat;
    e.acc   = cyc;
    sb.push_back(e);
    $display("req txn%0d we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h", txn_id, we, size, uns, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'h0, (sb.size() == 0 && req_ready)}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = 32'h80FF7F01;
    mem[3] = 32'h11223344;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

    @(negedge clk);
    check("reset_req_ready", {31'h0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_mem_op",    {31'h0, mem_op},    32'h0);
    check("reset_mem_addr",  mem_addr,  32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load
    wc0 = wr_count;
    issue(1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    wait_done();
    check("sw_wr_cycles", 32'(wr_count - wc0), 32'd1);
    check("sw_wr_addr", last_wr_addr, 32'h1004);
    check("sw_wr_data", last_wr_data, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    wait_done();

    // Sub-word loads from 0x80FF7F01
    wc0 = wr_count;
    issue(1'b0, 2'b00, 1'b0, 32'h100B, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h100A, 32'h0, 32'h000000FF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h1008, 32'h0, 32'h00007F01, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h100A, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h100A, 32'h0, 32'h000080FF, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h1009, 32'h0, 32'h0000007F, 1'b0, 2);
    wait_done();
    check("loads_no_write", 32'(wr_count - wc0), 32'd0);

    // Byte and half RMW stores
    wc0 = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'h100D, 32'h000000AB, 32'h0, 1'b0, 3);
    wait_done();
    check("sb_wr_cycles", 32'(wr_count - wc0), 32'd1);
    check("sb_wr_addr", last_wr_addr, 32'h100C);
    check("sb_wr_data", last_wr_data, 32'h1122AB44);
    issue(1'b1, 2'b01, 1'b0, 32'h100E, 32'h1234BEEF, 32'h0, 1'b0, 3);
    wait_done();
    check("sh_wr_data", last_wr_data, 32'hBEEFAB44);
    issue(1'b0, 2'b10, 1'b0, 32'h100C, 32'h0, 32'hBEEFAB44, 1'b0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'h00000000, 1'b0, 2);
    wait_done();

    // Error cases
    wc0 = wr_count;
    issue(1'b0, 2'b01, 1'b0, 32'h1001, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h1002, 32'h55555555, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b00, 1'b0, 32'h0FFF, 32'h12345678, 32'h0, 1'b1, 1);
    wait_done();
    check("err_no_write", 32'(wr_count - wc0), 32'd0);

    // Backpressure with a pending request
    rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, 32'h80FF7F01, 1'b0, 2);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h1004; req_wdata = 32'h0;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'h80FF7F01);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after_release", {31'h0, req_ready}, 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    wait_done();

    // Async reset during the WR of an RMW store
    issue(1'b1, 2'b00, 1'b0, 32'h1004, 32'h00000055, 32'h0, 1'b0, 3);
    for (int i = 0; i < 10 && !mem_op; i++) @(negedge clk);
    check("rst_saw_wr", {31'h0, mem_op}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_op_drop", {31'h0, mem_op}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    check("rst_no_cache_write", mem[1], 32'hDEADBEEF);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_response", {31'h0, rsp_valid}, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
